// File: rtl/end_screen_pkg.sv
// Shared types and constants for the end screen renderer.
// Contents: FSM state type, 3x5 digit font, palette colours, small pixel helpers.
package end_screen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FADE    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [7:0] WON_R_BASE  = 8'h7F;
    localparam logic [7:0] WON_G       = 8'hB0;
    localparam logic [7:0] WON_B       = 8'h8A;
    localparam logic [7:0] LOST_R      = 8'hFF;
    localparam logic [7:0] LOST_G_BASE = 8'h7A;
    localparam logic [7:0] LOST_B      = 8'h09;
    localparam logic [7:0] ICON_COLOR  = 8'hFF;
    localparam logic [7:0] DIGIT_COLOR = 8'hFF;

    // Glyph rows run top to bottom in bits [14:12]..[2:0]; bit 2 of a row is its leftmost column.
    localparam logic [14:0] FONT_ROM [10] = '{
        15'b111_101_101_101_111,
        15'b010_110_010_010_111,
        15'b111_001_111_100_111,
        15'b111_001_111_001_111,
        15'b101_101_111_001_001,
        15'b111_100_111_001_111,
        15'b111_100_111_101_111,
        15'b111_001_001_001_001,
        15'b111_101_111_101_111,
        15'b111_101_111_001_111
    };

    function automatic logic [2:0] font_row(input logic [3:0] digit, input logic [2:0] row);
        logic [14:0] glyph;
        glyph = (digit <= 4'd9) ? FONT_ROM[digit] : 15'd0;
        case (row)
            3'd0:    return glyph[14:12];
            3'd1:    return glyph[11:9];
            3'd2:    return glyph[8:6];
            3'd3:    return glyph[5:3];
            3'd4:    return glyph[2:0];
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic in_range(input logic signed [11:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        return (b == 8'hFF) ? c : 8'((16'(c) * 16'(b)) >> 8);
    endfunction

endpackage

// File: rtl/end_screen_renderer_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// done is high for one cycle once the final bit has been shifted in.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BCD_W+BIN_W-1:0] shift_q;
    logic [BCD_W+BIN_W-1:0] step_in;
    logic [BCD_W+BIN_W-1:0] step_out;
    logic [CNT_W-1:0]       count_q;
    logic                   active_q;

    // The start cycle already performs the first shift, so the whole run is BIN_W edges.
    always_comb begin
        step_in  = start ? {{BCD_W{1'b0}}, bin} : shift_q;
        step_out = step_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (step_out[BIN_W+4*d +: 4] >= 4'd5) begin
                step_out[BIN_W+4*d +: 4] = step_out[BIN_W+4*d +: 4] + 4'd3;
            end
        end
        step_out = step_out << 1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q  <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (clear) begin
            active_q <= 1'b0;
        end else if (start) begin
            shift_q  <= step_out;
            count_q  <= CNT_W'(BIN_W - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (count_q != '0) begin
                shift_q <= step_out;
                count_q <= count_q - 1'b1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign done = active_q && (count_q == '0);
    assign bcd  = shift_q[BCD_W+BIN_W-1 -: BCD_W];

endmodule

// File: rtl/end_screen_renderer.sv
// End-of-game screen: fades in a won/lost palette with an icon and the final score.
// Defining END_SCREEN_BLINK_EN makes the score digits blink 32 frames on / 32 off in HOLD.
module end_screen_renderer
    import end_screen_pkg::*;
#(
    parameter int CENTER_X  = 320,
    parameter int CENTER_Y  = 240,
    parameter int CELL_LOG2 = 4,
    parameter int SCORE_W   = 16,
    parameter int DIGITS    = 3,
    parameter int FADE_STEP = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               is_won,
    input  logic               is_lost,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               busy
);

    localparam int MAX_SCORE = 10 ** DIGITS - 1;
    localparam int FIELD_W   = DIGITS * 32;
    localparam int ORIGIN_X  = CENTER_X - DIGITS * 16;
    localparam int ORIGIN_Y  = CENTER_Y + 80;

    state_t                state;
    logic                  won_q;
    logic [SCORE_W-1:0]    score_q;
    logic [SCORE_W-1:0]    score_clamped;
    logic [7:0]            brightness;
    logic [8:0]            bright_sum;
    logic                  conv_start;
    logic                  conv_done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef END_SCREEN_BLINK_EN
    logic [5:0]            frame_cnt;
`endif

    assign score_clamped = (32'(score) > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : score;
    assign bright_sum    = {1'b0, brightness} + 9'(FADE_STEP);

    bin2bcd_seq #(
        .BIN_W  (SCORE_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (Clk),
        .reset_n (Reset_n),
        .clear   (state == IDLE),
        .start   (conv_start),
        .bin     (score_q),
        .bcd     (bcd),
        .done    (conv_done)
    );

    // Dropping both outcome flags aborts whatever is in progress, ahead of normal progress.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            won_q      <= 1'b0;
            score_q    <= '0;
            brightness <= '0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
`ifdef END_SCREEN_BLINK_EN
            frame_cnt  <= '0;
`endif
        end else begin
            conv_start <= 1'b0;
            if (state != IDLE && !is_won && !is_lost) begin
                state      <= IDLE;
                brightness <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_won || is_lost) begin
                            won_q      <= is_won;
                            score_q    <= score_clamped;
                            conv_start <= 1'b1;
                            brightness <= '0;
                            busy       <= 1'b1;
                            state      <= CONVERT;
                        end
                    end
                    CONVERT: begin
                        if (conv_done) begin
                            brightness <= '0;
                            state      <= FADE;
                        end
                    end
                    FADE: begin
                        if (frame_tick) begin
                            if (bright_sum >= 9'd255) begin
                                brightness <= 8'hFF;
                                busy       <= 1'b0;
                                state      <= HOLD;
`ifdef END_SCREEN_BLINK_EN
                                frame_cnt  <= '0;
`endif
                            end else begin
                                brightness <= bright_sum[7:0];
                            end
                        end
                    end
                    HOLD: begin
                        brightness <= 8'hFF;
`ifdef END_SCREEN_BLINK_EN
                        if (frame_tick) begin
                            frame_cnt <= frame_cnt + 6'd1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic signed [11:0] dx_raw, dy_raw, dx, dy;
    logic signed [11:0] rel_x, rel_y;
    logic               icon_hit;
    logic               in_field;
    logic               digits_visible;
    logic               digit_hit;
    logic [2:0]         digit_idx;
    logic [3:0]         digit_val;
    logic [2:0]         font_bits;
    logic [7:0]         bg_shift;
    logic [23:0]        pix;

    assign dx_raw = 12'(CENTER_X) - {2'b00, DrawX};
    assign dy_raw = 12'(CENTER_Y) - {2'b00, DrawY};
    assign dx     = dx_raw >>> CELL_LOG2;
    assign dy     = dy_raw >>> CELL_LOG2;

    assign icon_hit = (in_range(dy, 2, 2)   && in_range(dx, 0, 0))
                   || (in_range(dy, 1, 1)   && in_range(dx, -1, 1))
                   || (in_range(dy, 0, 0)   && in_range(dx, -3, 3))
                   || (in_range(dy, -3, -1) && in_range(dx, -4, 4));

    assign rel_x     = {2'b00, DrawX} - 12'(ORIGIN_X);
    assign rel_y     = {2'b00, DrawY} - 12'(ORIGIN_Y);
    assign in_field  = in_range(rel_x, 0, FIELD_W - 1) && in_range(rel_y, 0, 39)
                    && (rel_x[4:3] != 2'b11);
    assign digit_idx = rel_x[7:5];

    // Digit slot 0 is the leftmost, i.e. the most significant BCD nibble.
    always_comb begin
        digit_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == 3'(DIGITS - 1 - i)) begin
                digit_val = bcd[4*i +: 4];
            end
        end
    end

    assign font_bits = font_row(digit_val, rel_y[5:3]);

`ifdef END_SCREEN_BLINK_EN
    assign digits_visible = (state == FADE) || (state == HOLD && !frame_cnt[5]);
`else
    assign digits_visible = (state == FADE) || (state == HOLD);
`endif

    assign digit_hit = in_field && digits_visible && font_bits[2'd2 - rel_x[4:3]];
    assign bg_shift  = {1'b0, DrawX[9:3]};

    always_comb begin
        if (icon_hit) begin
            pix = {ICON_COLOR, ICON_COLOR, ICON_COLOR};
        end else if (digit_hit) begin
            pix = {DIGIT_COLOR, DIGIT_COLOR, DIGIT_COLOR};
        end else if (won_q) begin
            pix = {WON_R_BASE - bg_shift, WON_G, WON_B};
        end else begin
            pix = {LOST_R, LOST_G_BASE - bg_shift, LOST_B};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n || state == IDLE) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            VGA_R <= scale_channel(pix[23:16], brightness);
            VGA_G <= scale_channel(pix[15:8],  brightness);
            VGA_B <= scale_channel(pix[7:0],   brightness);
        end
    end

endmodule
